// File: rtl/matmul_seq_ctrl_if.sv
// matmul_seq_ctrl_if: operand/result RAM, MAC array and go/done signals of the matmul sequencer
interface matmul_seq_ctrl_if #(parameter int N = 8, parameter int LANES = 4);
  localparam int KW = $clog2(N);
  logic go;
  logic busy;
  logic done;
  logic [15:0] cycle_count;
  logic [KW-1:0] ram_a_addr;
  logic [8*N-1:0] ram_a_rdata;
  logic [2*KW-1:0] ram_b_addr;
  logic [7:0] ram_b_rdata;
  logic [8*LANES-1:0] mac_a;
  logic [7:0] mac_b;
  logic mac_clear;
  logic mac_start;
  logic [19*LANES-1:0] mac_out;
  logic ram_c_we;
  logic [2*KW-1:0] ram_c_addr;
  logic [18:0] ram_c_wdata;
  modport master (
    input go, ram_a_rdata, ram_b_rdata, mac_out,
    output busy, done, cycle_count, ram_a_addr, ram_b_addr, mac_a, mac_b,
    output mac_clear, mac_start, ram_c_we, ram_c_addr, ram_c_wdata
  );
  modport slave (
    output go, ram_a_rdata, ram_b_rdata, mac_out,
    input busy, done, cycle_count, ram_a_addr, ram_b_addr, mac_a, mac_b,
    input mac_clear, mac_start, ram_c_we, ram_c_addr, ram_c_wdata
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequences operand reads, MAC lane control and C writes for C = A x B
module matmul_seq_ctrl #(parameter int N = 8, parameter int LANES = 4) (
  input logic clk,
  input logic rst,
  matmul_seq_ctrl_if.master bus
);
  localparam int KW = $clog2(N);
  localparam int LW = $clog2(LANES);
  localparam int HW = $clog2(N / LANES);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, WRITE, DONE} state_t;
  state_t r_state;
  logic [KW-1:0] r_c, r_j, r_a_addr;
  logic [LW-1:0] r_l;
  logic [HW-1:0] r_h;
  logic [2*KW-1:0] r_b_addr, r_c_addr;
  logic [15:0] r_count;
  logic r_busy, r_done, r_clear, r_start, r_we;
  logic w_last;
  assign w_last = (&r_j) && (&r_h);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_c <= '0;
      r_j <= '0;
      r_l <= '0;
      r_h <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_c_addr <= '0;
      r_count <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_clear <= 1'b0;
      r_start <= 1'b0;
      r_we <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      case (r_state)
        IDLE: if (bus.go) begin
          r_state <= CLEAR;
          r_j <= '0;
          r_h <= '0;
          r_count <= '0;
          r_busy <= 1'b1;
          r_clear <= 1'b1;
          r_a_addr <= '0;
          r_b_addr <= '0;
        end
        CLEAR: begin
          r_state <= RUN;
          r_c <= '0;
          r_clear <= 1'b0;
          r_start <= 1'b1;
          r_a_addr <= KW'(1);
          r_b_addr <= {r_j, KW'(1)};
        end
        RUN: if (&r_c) begin
          r_state <= WRITE;
          r_start <= 1'b0;
          r_we <= 1'b1;
          r_l <= '0;
          r_c_addr <= {r_h, LW'(0), r_j};
        end else begin
          r_c <= r_c + KW'(1);
          if (r_c != KW'(N - 2)) begin
            r_a_addr <= r_c + KW'(2);
            r_b_addr <= {r_j, r_c + KW'(2)};
          end
        end
        WRITE: begin
          r_l <= r_l + LW'(1);
          r_c_addr <= {r_h, r_l + LW'(1), r_j};
          if (&r_l) begin
            r_we <= 1'b0;
            if (w_last) begin
              r_state <= DONE;
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_state <= CLEAR;
              r_clear <= 1'b1;
              r_h <= r_h + HW'(1);
              if (&r_h) r_j <= r_j + KW'(1);
              r_a_addr <= '0;
              r_b_addr <= {(&r_h) ? r_j + KW'(1) : r_j, KW'(0)};
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.cycle_count = r_count;
  assign bus.ram_a_addr = r_a_addr;
  assign bus.ram_b_addr = r_b_addr;
  assign bus.mac_clear = r_clear;
  assign bus.mac_start = r_start;
  assign bus.ram_c_we = r_we;
  assign bus.ram_c_addr = r_c_addr;
  assign bus.mac_a = bus.ram_a_rdata[8*LANES*r_h +: 8*LANES];
  assign bus.mac_b = bus.ram_b_rdata;
  assign bus.ram_c_wdata = r_we ? bus.mac_out[19*r_l +: 19] : '0;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: scoreboard bench with operand RAM and MAC lane models around matmul_seq_ctrl
module tb_matmul_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  matmul_seq_ctrl_if #(.N(8), .LANES(4)) bus();
  matmul_seq_ctrl #(.N(8), .LANES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [5:0] addr; logic [18:0] data;} exp_t;
  exp_t q[$];
  logic signed [7:0] ma [8][8];
  logic signed [7:0] mb [8][8];
  logic signed [18:0] acc [4];
  int n_cmp = 0;
  int n_bad = 0;
  function automatic logic signed [18:0] prod(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    return {{3{p[15]}}, p};
  endfunction
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) bus.ram_a_rdata[8*i +: 8] <= ma[i][bus.ram_a_addr];
    bus.ram_b_rdata <= mb[bus.ram_b_addr[2:0]][bus.ram_b_addr[5:3]];
    for (int l = 0; l < 4; l++)
      acc[l] <= bus.mac_clear ? 19'sd0 : bus.mac_start ? acc[l] + prod(bus.mac_a[8*l +: 8], bus.mac_b) : acc[l];
  end
  assign bus.mac_out = {acc[3], acc[2], acc[1], acc[0]};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push_exp;
    for (int j = 0; j < 8; j++)
      for (int h = 0; h < 2; h++)
        for (int l = 0; l < 4; l++) begin
          int i, s;
          exp_t e;
          i = 4 * h + l;
          s = 0;
          for (int k = 0; k < 8; k++) s += int'(ma[i][k]) * int'(mb[k][j]);
          e.addr = 6'(i * 8 + j);
          e.data = 19'(s);
          q.push_back(e);
        end
  endtask
  task automatic fill_id;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        mb[r][c] = 8'(r * 8 + c - 32);
      end
  endtask
  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = a;
        mb[r][c] = b;
      end
  endtask
  task automatic fill_rand;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = 8'($urandom);
        mb[r][c] = 8'($urandom);
      end
  endtask
  task automatic check_zero(input string t);
    chk({t, "_busy"}, bus.busy, 0);
    chk({t, "_done"}, bus.done, 0);
    chk({t, "_clear"}, bus.mac_clear, 0);
    chk({t, "_start"}, bus.mac_start, 0);
    chk({t, "_we"}, bus.ram_c_we, 0);
    chk({t, "_a_addr"}, bus.ram_a_addr, 0);
    chk({t, "_b_addr"}, bus.ram_b_addr, 0);
    chk({t, "_c_addr"}, bus.ram_c_addr, 0);
    chk({t, "_wdata"}, bus.ram_c_wdata, 0);
    chk({t, "_count"}, bus.cycle_count, 0);
  endtask
  task automatic wait_accept;
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.busy && w < 10);
    chk("go_accept", bus.busy, 1);
  endtask
  task automatic run(input bit hold, input bit wave);
    int n;
    push_exp();
    bus.go = 1'b1;
    wait_accept();
    if (!hold) bus.go = 1'b0;
    chk("count_start", bus.cycle_count, 0);
    n = 1;
    while (bus.busy && n < 300) begin
      if (wave && n == 1) begin
        chk("w1_clear", bus.mac_clear, 1);
        chk("w1_start", bus.mac_start, 0);
        chk("w1_a_addr", bus.ram_a_addr, 0);
        chk("w1_b_addr", bus.ram_b_addr, 0);
      end
      if (wave && n >= 2 && n <= 9) begin
        chk("wrun_start", bus.mac_start, 1);
        chk("wrun_clear", bus.mac_clear, 0);
        chk("wrun_we", bus.ram_c_we, 0);
      end
      if (wave && n >= 10 && n <= 13) begin
        chk("wwr_we", bus.ram_c_we, 1);
        chk("wwr_start", bus.mac_start, 0);
      end
      if (wave && n == 14) chk("w14_clear", bus.mac_clear, 1);
      if (n == 100) chk("count_mid", bus.cycle_count, 99);
      @(negedge clk);
      n++;
    end
    chk("done_cycle", n, 209);
    chk("done_pulse", bus.done, 1);
    chk("count_final", bus.cycle_count, 208);
    @(negedge clk);
    chk("no_restart", bus.busy, 0);
    chk("done_low", bus.done, 0);
    chk("count_hold", bus.cycle_count, 208);
    chk("writes_left", q.size(), 0);
    bus.go = 1'b0;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ram_c_we) begin
        if (q.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          e = q.pop_front();
          chk("c_addr", bus.ram_c_addr, e.addr);
          chk("c_data", bus.ram_c_wdata, e.data);
        end
      end
    end
  end
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin : main
    int cnt;
    bus.go = 1'b0;
    fill_id();
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");
    run(0, 1);
    fill_const(8'h80, 8'h80);
    run(0, 0);
    fill_const(8'h7F, 8'h80);
    run(0, 0);
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run(0, 0);
    end
    fill_rand();
    run(1, 0);
    fill_rand();
    push_exp();
    bus.go = 1'b1;
    wait_accept();
    bus.go = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_zero("mid_rst");
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(bus.ram_c_we);
    end
    chk("we_after_rst", cnt, 0);
    chk("idle_after_rst", bus.busy, 0);
    fill_rand();
    run(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
